// File: rtl/key_judge_pkg.sv
// key_judge_pkg: lane encodings, judge FSM states, default keycodes and
// the lane constants shared with the note-pattern generator.
package key_judge_pkg;

   typedef logic [2:0] lane_t;

   localparam lane_t LANE_NONE = 3'b000;
   localparam lane_t LANE_L    = 3'b100;
   localparam lane_t LANE_M    = 3'b010;
   localparam lane_t LANE_R    = 3'b001;

   // Lane set the pattern generator draws from, index 0 = left .. 2 = right
   localparam int    GEN_LANE_CNT = 3;
   localparam lane_t GEN_LANES [GEN_LANE_CNT] = '{LANE_L, LANE_M, LANE_R};

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_L_DEF = 8'h04;
   localparam logic [7:0] KEY_M_DEF = 8'h16;
   localparam logic [7:0] KEY_R_DEF = 8'h07;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_PRESS   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_OVER    = 3'd4
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/key_judge_decode.sv
// key_decode: maps a USB keycode onto a one-hot lane; unmapped or zero
// keycodes produce valid = 0 and lane = LANE_NONE.
module key_decode
   import key_judge_pkg::*;
#(
   parameter logic [7:0] KEY_L = KEY_L_DEF,
   parameter logic [7:0] KEY_M = KEY_M_DEF,
   parameter logic [7:0] KEY_R = KEY_R_DEF
)(
   input  logic [7:0] keycode,
   output lane_t      lane,
   output logic       valid
);

   // Pure lookup; keycode 0 never decodes even if a lane key is set to 0
   always_comb begin
      lane  = LANE_NONE;
      valid = 1'b0;
      if (keycode != KEY_NONE) begin
         if (keycode == KEY_L) begin
            lane  = LANE_L;
            valid = 1'b1;
         end else if (keycode == KEY_M) begin
            lane  = LANE_M;
            valid = 1'b1;
         end else if (keycode == KEY_R) begin
            lane  = LANE_R;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_judge.sv
// key_judge: judges player key presses against the current pattern row,
// keeps score/combo/miss counts and decides game over / win.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | after reset, waiting for StartGame
//   ST_ARM     | game started, waiting for all keys up before judging
//   ST_PRESS   | expected lane latched, judging keys, frame timer runs
//   ST_RELEASE | key judged, waiting for key up
//   ST_OVER    | game ended (win or loss), outputs frozen
module key_judge
   import key_judge_pkg::*;
#(
   parameter logic [7:0] KEY_L      = KEY_L_DEF,
   parameter logic [7:0] KEY_M      = KEY_M_DEF,
   parameter logic [7:0] KEY_R      = KEY_R_DEF,
   parameter int         TIMEOUT_FR = 90,
   parameter int         MAX_MISS   = 5,
   parameter int         ROWS       = 100
)(
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 StartGame,
   input  logic                 frame_tick,
   input  logic [7:0]           keycode,
   input  logic [ROWS-1:0][2:0] array_in,
   input  logic [6:0]           row_counter1,
   output logic                 correct_key1,
   output logic                 wrong_key,
   output logic                 is_GameOver,
   output logic                 win,
   output logic [15:0]          score,
   output logic [7:0]           combo,
   output logic [3:0]           misses
);

   localparam int            FW      = $clog2(TIMEOUT_FR + 1);
   localparam logic [FW-1:0] FR_LOAD = FW'(TIMEOUT_FR);
   localparam logic [FW-1:0] FR_TC   = FW'(1);

   logic          rst_meta;
   logic          rst_n;
   state_t        state;
   lane_t         exp_lane;
   lane_t         key_lane;
   logic          key_valid;
   logic [FW-1:0] frame_cnt;
   logic          row_oob;
   logic          row_last;
   logic          miss_limit;
   logic          abort;
   logic          press_exit;
   logic          timeout_hit;

   key_decode #(
      .KEY_L (KEY_L),
      .KEY_M (KEY_M),
      .KEY_R (KEY_R)
   ) u_decode (
      .keycode (keycode),
      .lane    (key_lane),
      .valid   (key_valid)
   );

   // Reset asserts immediately, releases two clk edges after Reset rises
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   assign row_oob    = (int'(row_counter1) >= ROWS);
   assign row_last   = (int'(row_counter1) == ROWS - 1);
   assign miss_limit = (int'(misses) >= MAX_MISS);
   assign abort      = row_oob || miss_limit;

   // Any event that takes PRESS elsewhere this cycle; a judged key beats a timeout
   assign press_exit  = StartGame || abort || key_valid;
   assign timeout_hit = (state == ST_PRESS) && frame_tick && !press_exit
                        && (frame_cnt == FR_TC);

   // Frame timeout down-counter, reloaded whenever PRESS is not being held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if ((state != ST_PRESS) || press_exit) begin
         frame_cnt <= FR_LOAD;
      end else if (frame_tick) begin
         frame_cnt <= (frame_cnt == FR_TC) ? FR_LOAD : frame_cnt - FR_TC;
      end
   end

   // Judge FSM with registered pulses and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         exp_lane     <= LANE_NONE;
         correct_key1 <= 1'b0;
         wrong_key    <= 1'b0;
         is_GameOver  <= 1'b0;
         win          <= 1'b0;
         score        <= '0;
         combo        <= '0;
         misses       <= '0;
      end else begin
         correct_key1 <= 1'b0;
         wrong_key    <= 1'b0;
         if (StartGame) begin
            state       <= ST_ARM;
            is_GameOver <= 1'b0;
            win         <= 1'b0;
            score       <= '0;
            combo       <= '0;
            misses      <= '0;
         end else begin
            unique case (state)
               ST_IDLE: begin
               end
               ST_ARM, ST_RELEASE: begin
                  if (abort) begin
                     state       <= ST_OVER;
                     is_GameOver <= 1'b1;
                     win         <= 1'b0;
                  end else if (keycode == KEY_NONE) begin
                     exp_lane <= array_in[row_counter1];
                     state    <= ST_PRESS;
                  end
               end
               ST_PRESS: begin
                  if (abort) begin
                     state       <= ST_OVER;
                     is_GameOver <= 1'b1;
                     win         <= 1'b0;
                  end else if (key_valid) begin
                     if (key_lane == exp_lane) begin
                        correct_key1 <= 1'b1;
                        score        <= sat_inc16(score);
                        combo        <= sat_inc8(combo);
                        if (row_last) begin
                           state       <= ST_OVER;
                           is_GameOver <= 1'b1;
                           win         <= 1'b1;
                        end else begin
                           state <= ST_RELEASE;
                        end
                     end else begin
                        wrong_key <= 1'b1;
                        misses    <= misses + 4'd1;
                        combo     <= '0;
                        state     <= ST_RELEASE;
                     end
                  end else if (timeout_hit) begin
                     wrong_key <= 1'b1;
                     misses    <= misses + 4'd1;
                     combo     <= '0;
                  end
               end
               ST_OVER: begin
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_judge.sv
// tb_key_judge: directed scenarios plus randomized play, every cycle
// compared against a phase-level behavioural model of the judge.
module tb_key_judge;

   localparam int TO   = 3;
   localparam int MAXM = 5;
   localparam int NR   = 100;

   localparam int PH_IDLE = 0;
   localparam int PH_WAIT = 1;   // game running, waiting for all keys up
   localparam int PH_PLAY = 2;   // game running, judging presses
   localparam int PH_DONE = 3;

   logic              clk = 1'b0;
   logic              Reset;
   logic              StartGame;
   logic              frame_tick;
   logic [7:0]        keycode;
   logic [NR-1:0][2:0] arr;
   logic [6:0]        row_counter1;
   logic              correct_key1;
   logic              wrong_key;
   logic              is_GameOver;
   logic              win;
   logic [15:0]       score;
   logic [7:0]        combo;
   logic [3:0]        misses;

   int n_chk  = 0;
   int n_pass = 0;

   int       m_phase;
   int       m_frames;
   int       m_score;
   int       m_combo;
   int       m_misses;
   logic [2:0] m_exp;
   bit       m_correct;
   bit       m_wrong;
   bit       m_go;
   bit       m_win;

   key_judge #(
      .TIMEOUT_FR (TO),
      .MAX_MISS   (MAXM),
      .ROWS       (NR)
   ) dut (
      .clk          (clk),
      .Reset        (Reset),
      .StartGame    (StartGame),
      .frame_tick   (frame_tick),
      .keycode      (keycode),
      .array_in     (arr),
      .row_counter1 (row_counter1),
      .correct_key1 (correct_key1),
      .wrong_key    (wrong_key),
      .is_GameOver  (is_GameOver),
      .win          (win),
      .score        (score),
      .combo        (combo),
      .misses       (misses)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [2:0] key_lane(input logic [7:0] k);
      if (k == 8'h04) return 3'b100;
      if (k == 8'h16) return 3'b010;
      if (k == 8'h07) return 3'b001;
      return 3'b000;
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE; m_frames = 0; m_exp = 3'b000;
      m_score = 0; m_combo = 0; m_misses = 0;
      m_correct = 0; m_wrong = 0; m_go = 0; m_win = 0;
   endtask

   task automatic add_miss();
      m_wrong = 1;
      m_misses = m_misses + 1;
      m_combo = 0;
   endtask

   // One clock edge of game rules, applied to the inputs seen at that edge
   task automatic model_step();
      logic [2:0] lane;
      m_correct = 0;
      m_wrong   = 0;
      if (!Reset) begin
         model_reset();
         return;
      end
      lane = key_lane(keycode);
      if (StartGame) begin
         m_phase = PH_WAIT; m_score = 0; m_combo = 0; m_misses = 0;
         m_go = 0; m_win = 0; m_frames = 0;
      end else if (m_phase == PH_WAIT || m_phase == PH_PLAY) begin
         if (int'(row_counter1) >= NR || m_misses >= MAXM) begin
            m_phase = PH_DONE; m_go = 1; m_win = 0;
         end else if (m_phase == PH_WAIT) begin
            if (keycode == 8'h00) begin
               m_phase = PH_PLAY; m_exp = arr[row_counter1]; m_frames = 0;
            end
         end else if (lane != 3'b000) begin
            m_frames = 0;
            if (lane == m_exp) begin
               m_correct = 1;
               if (m_score < 65535) m_score = m_score + 1;
               if (m_combo < 255) m_combo = m_combo + 1;
               if (int'(row_counter1) == NR - 1) begin
                  m_phase = PH_DONE; m_go = 1; m_win = 1;
               end else begin
                  m_phase = PH_WAIT;
               end
            end else begin
               add_miss();
               m_phase = PH_WAIT;
            end
         end else if (frame_tick) begin
            m_frames = m_frames + 1;
            if (m_frames == TO) begin
               add_miss();
               m_frames = 0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("correct_key1", correct_key1, m_correct);
      chk("wrong_key", wrong_key, m_wrong);
      chk("is_GameOver", is_GameOver, m_go);
      chk("win", win, m_win);
      chk("score", score, m_score);
      chk("combo", combo, m_combo);
      chk("misses", misses, m_misses);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_correct"}, correct_key1, 0);
      chk({tag, "_wrong"}, wrong_key, 0);
      chk({tag, "_over"}, is_GameOver, 0);
      chk({tag, "_win"}, win, 0);
      chk({tag, "_score"}, score, 0);
      chk({tag, "_combo"}, combo, 0);
      chk({tag, "_misses"}, misses, 0);
   endtask

   task automatic start_game();
      StartGame = 1'b1;
      step();
      StartGame = 1'b0;
   endtask

   int cnt_ok;
   int cnt_bad;
   int sel;

   initial begin
      model_reset();
      Reset = 1'b0; StartGame = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
      row_counter1 = 7'd0;
      for (int r = 0; r < NR; r++) arr[r] = 3'b100 >> $urandom_range(0, 2);

      // reset state
      step(); step();
      chk_all_zero("reset");
      Reset = 1'b1;
      repeat (4) step();

      // correct first hit
      arr[0] = 3'b100; row_counter1 = 7'd0;
      start_game();
      step();
      keycode = 8'h04;
      step();
      chk("t023_pulse", correct_key1, 1);
      chk("t023_score", score, 1);
      chk("t023_combo", combo, 1);
      step();
      chk("t023_one_cycle", correct_key1, 0);

      // wrong key, then held key gives nothing more
      row_counter1 = 7'd1; arr[1] = 3'b010;
      keycode = 8'h00; step();
      keycode = 8'h07; step();
      chk("t024_wrong", wrong_key, 1);
      chk("t024_misses", misses, 1);
      chk("t024_combo", combo, 0);
      cnt_bad = 0; cnt_ok = 0;
      repeat (10) begin
         step();
         if (wrong_key) cnt_bad++;
         if (correct_key1) cnt_ok++;
      end
      chk("t024_hold_wrong", cnt_bad, 0);
      chk("t024_hold_correct", cnt_ok, 0);

      // press and timeout in the same cycle
      row_counter1 = 7'd2; arr[2] = 3'b001;
      keycode = 8'h00; step();
      frame_tick = 1'b1; step(); step();
      keycode = 8'h07; step();
      frame_tick = 1'b0;
      chk("t026_correct", correct_key1, 1);
      chk("t026_no_wrong", wrong_key, 0);
      chk("t026_misses", misses, 1);

      // timeouts end the game
      keycode = 8'h00;
      start_game();
      step();
      cnt_bad = 0;
      frame_tick = 1'b1;
      repeat (15) begin
         step();
         if (wrong_key) cnt_bad++;
      end
      frame_tick = 1'b0;
      step();
      if (wrong_key) cnt_bad++;
      chk("t025_pulses", cnt_bad, 5);
      chk("t025_over", is_GameOver, 1);
      chk("t025_win", win, 0);

      // last row cleared
      row_counter1 = 7'd99; arr[99] = 3'b100;
      start_game();
      step();
      keycode = 8'h04; step();
      chk("t027_over", is_GameOver, 1);
      chk("t027_win", win, 1);
      cnt_ok = 0; cnt_bad = 0;
      for (int i = 0; i < 8; i++) begin
         keycode = (i % 2 == 0) ? 8'h00 : ((i % 4 == 1) ? 8'h04 : 8'h07);
         frame_tick = 1'b1;
         step();
         if (correct_key1) cnt_ok++;
         if (wrong_key) cnt_bad++;
      end
      frame_tick = 1'b0;
      chk("t027_after_correct", cnt_ok, 0);
      chk("t027_after_wrong", cnt_bad, 0);
      chk("t027_score_held", score, 1);

      // reset in RELEASE, then key held through StartGame
      row_counter1 = 7'd0; keycode = 8'h00;
      start_game();
      step();
      keycode = 8'h04; step(); step();
      #2 Reset = 1'b0;
      #1 chk_all_zero("t028_async");
      model_reset();
      step(); step();
      Reset = 1'b1;
      repeat (4) step();
      keycode = 8'h04;
      start_game();
      cnt_ok = 0;
      repeat (5) begin
         step();
         if (correct_key1) cnt_ok++;
      end
      chk("t028_held_start", cnt_ok, 0);
      keycode = 8'h00; step();
      keycode = 8'h04; step();
      chk("t028_repress", correct_key1, 1);

      // randomized play, row advances like the pattern generator
      for (int r = 0; r < NR; r++) arr[r] = 3'b100 >> $urandom_range(0, 2);
      row_counter1 = 7'd0;
      for (int i = 0; i < 3000; i++) begin
         StartGame = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 3) == 0) begin
            sel = $urandom_range(0, 5);
            case (sel)
               0, 1:    keycode = 8'h00;
               2:       keycode = 8'h04;
               3:       keycode = 8'h16;
               4:       keycode = 8'h07;
               default: keycode = 8'($urandom_range(1, 255));
            endcase
         end
         frame_tick = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 399) == 0) row_counter1 = 7'($urandom_range(0, 127));
         step();
         if (StartGame) row_counter1 = 7'd0;
         else if (m_correct) row_counter1 = row_counter1 + 7'd1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
